// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with valid/ready word input.
// Each bit is held DIV cycles; words stream back to back with no idle gap.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV        = 1,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic             o_out,
  output logic             o_out_vld,
  output logic             o_last,
  output logic             o_busy
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_MAX  = DCW'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [BCW-1:0]   bit_cnt;
  logic [DCW-1:0]   div_cnt;

  logic div_end;
  logic accept;

  // Output and handshake decode, from registered state only
  assign div_end   = (div_cnt == DIV_MAX);
  assign o_out_vld = (state == SHIFT);
  assign o_busy    = (state == SHIFT);
  assign o_last    = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign o_rdy     = (state == IDLE) || (o_last && div_end);
  assign o_out     = (state == SHIFT) ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LEVEL;
  assign accept    = i_vld && o_rdy;

  // Word load, bit pacing and shift sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      state   <= SHIFT;
      sr      <= i_data;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (div_end) begin
        div_cnt <= '0;
        if (o_last) begin
          state   <= IDLE;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
          sr      <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        end
      end else begin
        div_cnt <= div_cnt + DCW'(1);
      end
    end
  end

endmodule
